reg_scoreboard: RTL and testbench

- Register-file hazard scheduler between the decode stage and downstream execute/writeback.
- Holds a per-register busy bit for every destination register with a write still in flight.
- Gates instruction issue until source and destination operands are free.
- Accepts writeback completions and pipeline flushes, and keeps an in-flight count and a stall performance counter.

---
 rtl/reg_scoreboard.sv | 130 +++++++++++++
 tb/tb_reg_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register-file hazard scoreboard sitting between decode and execute/writeback.
// Tracks one busy bit per architectural register with a write in flight,
// gates issue on RAW/WAW hazards and on in-flight capacity, and accepts
// writeback completions and pipeline flushes. Also keeps an in-flight
// count, a saturating stall counter and a sticky spurious-writeback flag.
// There is no sequencing FSM: all state is the busy vector and counters.
module reg_scoreboard #(
   parameter int MAX_INFLIGHT = 4,
   parameter bit WB_BYPASS    = 1'b1,
   localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue_valid,
   input  logic [4:0]    issue_rs1,
   input  logic [4:0]    issue_rs2,
   input  logic [4:0]    issue_rd,
   input  logic          issue_uses_rs1,
   input  logic          issue_uses_rs2,
   input  logic          issue_writes_rd,
   output logic          issue_ready,
   input  logic          wb_valid,
   input  logic [4:0]    wb_rd,
   input  logic          flush,
   output logic [31:0]   busy,
   output logic [CW-1:0] inflight_count,
   output logic [31:0]   stall_cycles,
   output logic          wb_err
);

   localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_INFLIGHT);
   localparam logic [31:0]   STALL_MAX = 32'hFFFF_FFFF;

   logic [31:0]   wb_mask;
   logic [31:0]   eff_busy;
   logic          rd_nz;
   logic          hazard;
   logic          retiring;
   logic          spurious_wb;
   logic          full;
   logic          issue_fire;
   logic          fire_write;
   logic          retire_eff;
   logic [31:0]   busy_nxt;
   logic [CW-1:0] count_nxt;
   logic          stall_now;

   // Writeback view: with bypass, a register retiring this cycle already reads as free.
   always_comb begin
      wb_mask = '0;
      if (wb_valid) begin
         wb_mask = 32'd1 << wb_rd;
      end
      eff_busy = busy;
      if (WB_BYPASS) begin
         eff_busy = busy & ~wb_mask;
      end
      eff_busy[0] = 1'b0;
   end

   // Hazard detection, capacity check and the issue handshake.
   always_comb begin
      rd_nz       = issue_writes_rd && (issue_rd != 5'd0);
      hazard      = (issue_uses_rs1 && eff_busy[issue_rs1]) ||
                    (issue_uses_rs2 && eff_busy[issue_rs2]) ||
                    (rd_nz && eff_busy[issue_rd]);
      retiring    = wb_valid && (wb_rd != 5'd0) && busy[wb_rd];
      spurious_wb = wb_valid && (wb_rd != 5'd0) && !busy[wb_rd];
      // A retiring write frees its slot this cycle, so it does not count as full.
      full        = (inflight_count == MAX_CNT) && !retiring;
      issue_ready = !rst && !flush && !hazard && !(full && rd_nz);
      issue_fire  = issue_valid && issue_ready;
      fire_write  = issue_fire && rd_nz;
      retire_eff  = retiring && !flush;
      stall_now   = !rst && !flush && issue_valid && !issue_ready;
   end

   // Next busy vector and count; a same-register set wins over the clear.
   always_comb begin
      busy_nxt  = busy;
      count_nxt = inflight_count;
      if (flush) begin
         busy_nxt  = '0;
         count_nxt = '0;
      end else begin
         if (retire_eff) begin
            busy_nxt[wb_rd] = 1'b0;
         end
         if (fire_write) begin
            busy_nxt[issue_rd] = 1'b1;
         end
         case ({fire_write, retire_eff})
            2'b10:   count_nxt = inflight_count + CW'(1);
            2'b01:   count_nxt = inflight_count - CW'(1);
            default: count_nxt = inflight_count;
         endcase
      end
      busy_nxt[0] = 1'b0;
   end

   // Busy vector and in-flight count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy           <= '0;
         inflight_count <= '0;
      end else begin
         busy           <= busy_nxt;
         inflight_count <= count_nxt;
      end
   end

   // Saturating stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (stall_now && (stall_cycles != STALL_MAX)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

   // Sticky error for a writeback to a register with nothing in flight; ignored during flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_err <= 1'b0;
      end else if (!flush && spurious_wb) begin
         wb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with MAX_INFLIGHT=4, WB_BYPASS=1.
// Inputs change 1ns after the rising edge; registered and combinational
// outputs are sampled at that same point, away from the edge.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rs1;
   logic [4:0]  issue_rs2;
   logic [4:0]  issue_rd;
   logic        issue_uses_rs1;
   logic        issue_uses_rs2;
   logic        issue_writes_rd;
   logic        issue_ready;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        flush;
   logic [31:0] busy;
   logic [2:0]  inflight_count;
   logic [31:0] stall_cycles;
   logic        wb_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   reg_scoreboard #(.MAX_INFLIGHT(4), .WB_BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_uses_rs1(issue_uses_rs1),
      .issue_uses_rs2(issue_uses_rs2), .issue_writes_rd(issue_writes_rd),
      .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .flush(flush), .busy(busy), .inflight_count(inflight_count),
      .stall_cycles(stall_cycles), .wb_err(wb_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_issue(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic [4:0] rd, input logic w);
      issue_valid     = v;
      issue_rs1       = rs1;
      issue_uses_rs1  = u1;
      issue_rs2       = rs2;
      issue_uses_rs2  = u2;
      issue_rd        = rd;
      issue_writes_rd = w;
   endtask

   task automatic drive_wb(input logic v, input logic [4:0] rd);
      wb_valid = v;
      wb_rd    = rd;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0;
      drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
      drive_wb(1'b0, 5'd0);
      tick(); tick();
      n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", issue_ready); end
      n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
      n_cmp++; if (inflight_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", inflight_count); end
      n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
      n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL reset_wberr got=%b exp=0", wb_err); end
      drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_raw();
      drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL raw_first_ready got=%b exp=1", issue_ready); end
      tick();
      n_cmp++; if (busy !== 32'h0000_0020) begin n_bad++; $display("FAIL raw_busy5 got=%h exp=00000020", busy); end
      drive_issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL raw_stall_ready got=%b exp=0", issue_ready); end
      tick();
      n_cmp++; if (stall_cycles !== 32'd1) begin n_bad++; $display("FAIL raw_stall1 got=%0d exp=1", stall_cycles); end
      tick();
      n_cmp++; if (stall_cycles !== 32'd2) begin n_bad++; $display("FAIL raw_stall2 got=%0d exp=2", stall_cycles); end
      drive_wb(1'b1, 5'd5);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL raw_bypass_ready got=%b exp=1", issue_ready); end
      tick();
      drive_wb(1'b0, 5'd0);
      drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL raw_busy_clear got=%h exp=0", busy); end
      n_cmp++; if (inflight_count !== 3'd0) begin n_bad++; $display("FAIL raw_count got=%0d exp=0", inflight_count); end
      n_cmp++; if (stall_cycles !== 32'd2) begin n_bad++; $display("FAIL raw_stall_hold got=%0d exp=2", stall_cycles); end
   endtask

   task automatic test_x0();
      drive_issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready got=%b exp=1", issue_ready); end
      tick();
      n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL x0_busy got=%h exp=0", busy); end
      n_cmp++; if (inflight_count !== 3'd0) begin n_bad++; $display("FAIL x0_count got=%0d exp=0", inflight_count); end
      drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      drive_wb(1'b1, 5'd0);
      tick();
      drive_wb(1'b0, 5'd0);
      n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL x0_wberr got=%b exp=0", wb_err); end
   endtask

   task automatic test_full();
      for (int r = 1; r <= 4; r++) begin
         drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1);
         #1;
         n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL full_fill_ready r=%0d got=%b exp=1", r, issue_ready); end
         tick();
      end
      drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      n_cmp++; if (inflight_count !== 3'd4) begin n_bad++; $display("FAIL full_count got=%0d exp=4", inflight_count); end
      n_cmp++; if (busy !== 32'h0000_001E) begin n_bad++; $display("FAIL full_busy got=%h exp=0000001e", busy); end
      drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
      #1;
      n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL full_writer_blocked got=%b exp=0", issue_ready); end
      drive_issue(1'b0, 5'd8, 1'b1, 5'd9, 1'b1, 5'd6, 1'b0);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL full_store_ready got=%b exp=1", issue_ready); end
      drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
      drive_wb(1'b1, 5'd2);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL full_retire_ready got=%b exp=1", issue_ready); end
      tick();
      drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      n_cmp++; if (busy !== 32'h0000_005A) begin n_bad++; $display("FAIL full_swap_busy got=%h exp=0000005a", busy); end
      n_cmp++; if (inflight_count !== 3'd4) begin n_bad++; $display("FAIL full_swap_count got=%0d exp=4", inflight_count); end
      drive_wb(1'b1, 5'd1); tick();
      drive_wb(1'b1, 5'd3); tick();
      drive_wb(1'b1, 5'd4); tick();
      drive_wb(1'b1, 5'd6); tick();
      drive_wb(1'b0, 5'd0);
      n_cmp++; if (inflight_count !== 3'd0) begin n_bad++; $display("FAIL full_drain_count got=%0d exp=0", inflight_count); end
      n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL full_drain_wberr got=%b exp=0", wb_err); end
   endtask

   task automatic test_same_cycle();
      drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
      tick();
      drive_wb(1'b1, 5'd7);
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL same_ready got=%b exp=1", issue_ready); end
      tick();
      drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      drive_wb(1'b0, 5'd0);
      n_cmp++; if (busy !== 32'h0000_0080) begin n_bad++; $display("FAIL same_busy got=%h exp=00000080", busy); end
      n_cmp++; if (inflight_count !== 3'd1) begin n_bad++; $display("FAIL same_count got=%0d exp=1", inflight_count); end
      drive_wb(1'b1, 5'd7);
      tick();
      drive_wb(1'b0, 5'd0);
      n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL same_clear got=%h exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
      tick();
      drive_issue(1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 5'd11, 1'b1);
      #1;
      n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_rs2_ready got=%b exp=0", issue_ready); end
      drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
      #1;
      n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_waw_ready got=%b exp=0", issue_ready); end
      drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      drive_wb(1'b1, 5'd10);
      tick();
      drive_wb(1'b0, 5'd0);
      n_cmp++; if (inflight_count !== 3'd0) begin n_bad++; $display("FAIL b2b_count got=%0d exp=0", inflight_count); end
   endtask

   task automatic test_flush();
      drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1); tick();
      drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1); tick();
      drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); tick();
      n_cmp++; if (busy !== 32'h0000_020A) begin n_bad++; $display("FAIL flush_setup_busy got=%h exp=0000020a", busy); end
      flush = 1'b1;
      drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
      drive_wb(1'b1, 5'd12);
      #1;
      n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got=%b exp=0", issue_ready); end
      tick();
      flush = 1'b0;
      drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      drive_wb(1'b0, 5'd0);
      n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL flush_busy got=%h exp=0", busy); end
      n_cmp++; if (inflight_count !== 3'd0) begin n_bad++; $display("FAIL flush_count got=%0d exp=0", inflight_count); end
      n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL flush_wberr got=%b exp=0", wb_err); end
      n_cmp++; if (stall_cycles !== 32'd2) begin n_bad++; $display("FAIL flush_stall got=%0d exp=2", stall_cycles); end
   endtask

   task automatic test_wb_err_and_reset();
      drive_wb(1'b1, 5'd12);
      tick();
      drive_wb(1'b0, 5'd0);
      n_cmp++; if (wb_err !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b exp=1", wb_err); end
      tick(); tick();
      n_cmp++; if (wb_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b exp=1", wb_err); end
      drive_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1); tick();
      drive_issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); tick();
      n_cmp++; if (stall_cycles !== 32'd3) begin n_bad++; $display("FAIL err_stall got=%0d exp=3", stall_cycles); end
      rst = 1'b1;
      #1;
      n_cmp++; if (issue_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", issue_ready); end
      tick();
      n_cmp++; if (busy !== 32'h0) begin n_bad++; $display("FAIL rst_busy got=%h exp=0", busy); end
      n_cmp++; if (inflight_count !== 3'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", inflight_count); end
      n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_stall got=%0d exp=0", stall_cycles); end
      n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL rst_wberr got=%b exp=0", wb_err); end
      rst = 1'b0;
      #1;
      n_cmp++; if (issue_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got=%b exp=1", issue_ready); end
      drive_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      drive_wb(1'b1, 5'd5);
      tick();
      drive_wb(1'b0, 5'd0);
      n_cmp++; if (wb_err !== 1'b1) begin n_bad++; $display("FAIL rst_stale_wb got=%b exp=1", wb_err); end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_x0();
      test_full();
      test_same_cycle();
      test_back_to_back();
      test_flush();
      test_wb_err_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
